// File: rtl/poc_pkg.sv
// Shared bus encodings, status-register layout and PIC state type used by the POC and PIC.
package poc_pkg;

  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b11;

  localparam logic A_SR = 1'b0;
  localparam logic A_BR = 1'b1;

  localparam int unsigned SR_RDY = 7;
  localparam int unsigned SR_OVR = 6;
  localparam int unsigned SR_IE  = 0;

  typedef enum logic [1:0] {IDLE, FULL, DRAIN} pic_state_t;

endpackage

// File: rtl/pic_cpu_if.sv
// CPU-side bus decode for the PIC: status register bits and the registered Dout read path.
module pic_cpu_if
  import poc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    RW,
  input  logic          ADDR,
  input  logic [DW-1:0] Din,
  input  logic [DW-1:0] br,
  input  logic          capture,
  input  logic          rd_clr,
  input  logic          ovr_set,
  output logic [DW-1:0] Dout,
  output logic          br_rd,
  output logic          sr_rdy_d,
  output logic          sr_ie_d
);

  logic          sr_rdy_q, sr_ovr_q, sr_ie_q, sr_ovr_d;
  logic [DW-1:0] dout_q, dout_d, sr_val;
  logic          bus_rd, sr_wr;

  // Only SR6 and SR0 are writable; the rest of Din is deliberately ignored.
  logic unused_din;
  assign unused_din = ^{Din[DW-1:SR_OVR+1], Din[SR_OVR-1:SR_IE+1]};

  always_comb begin
    bus_rd = (RW == RW_READ);
    sr_wr  = (RW == RW_WRITE) && (ADDR == A_SR);
    br_rd  = bus_rd && (ADDR == A_BR);

    sr_val         = '0;
    sr_val[SR_RDY] = sr_rdy_q;
    sr_val[SR_OVR] = sr_ovr_q;
    sr_val[SR_IE]  = sr_ie_q;

    sr_rdy_d = sr_rdy_q;
    if (capture) sr_rdy_d = 1'b1;
    else if (rd_clr) sr_rdy_d = 1'b0;

    // A fresh overrun in the same cycle as a clear is kept so it is not lost.
    sr_ovr_d = sr_ovr_q;
    if (sr_wr && Din[SR_OVR]) sr_ovr_d = 1'b0;
    if (ovr_set) sr_ovr_d = 1'b1;

    sr_ie_d = sr_ie_q;
    if (sr_wr) sr_ie_d = Din[SR_IE];

    dout_d = dout_q;
    if (bus_rd) dout_d = (ADDR == A_SR) ? sr_val : br;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_rdy_q <= 1'b0;
      sr_ovr_q <= 1'b0;
      sr_ie_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      sr_rdy_q <= sr_rdy_d;
      sr_ovr_q <= sr_ovr_d;
      sr_ie_q  <= sr_ie_d;
      dout_q   <= dout_d;
    end
  end

  assign Dout = dout_q;

endmodule

// File: rtl/pic_input_controller.sv
// Parallel input controller: captures device bytes on TR into BR and hands them to the CPU.
module pic_input_controller
  import poc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    RW,
  input  logic          ADDR,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] Dout,
  output logic          IRQ,
  input  logic          TR,
  input  logic [DW-1:0] PD,
  output logic          RDY
);

  pic_state_t    state_q, state_d;
  logic [DW-1:0] br_q, br_d;
  logic          tr_q, rdy_q, irq_q;
  logic          capture, rd_clr, ovr_set, br_rd, sr_rdy_d, sr_ie_d;

  pic_cpu_if #(
    .DW(DW)
  ) u_cpu_if (
    .CLK      (CLK),
    .RST      (RST),
    .RW       (RW),
    .ADDR     (ADDR),
    .Din      (Din),
    .br       (br_q),
    .capture  (capture),
    .rd_clr   (rd_clr),
    .ovr_set  (ovr_set),
    .Dout     (Dout),
    .br_rd    (br_rd),
    .sr_rdy_d (sr_rdy_d),
    .sr_ie_d  (sr_ie_d)
  );

  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    capture = 1'b0;
    rd_clr  = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TR) begin
          capture = 1'b1;
          br_d    = PD;
          state_d = FULL;
        end
      end
      FULL: begin
        // A read on the same edge as a new strobe wins; DRAIN then absorbs the strobe.
        if (br_rd) begin
          rd_clr  = 1'b1;
          state_d = DRAIN;
        end else if (TR && !tr_q) begin
          ovr_set = 1'b1;
        end
      end
      DRAIN: begin
        if (!TR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      br_q    <= '0;
      tr_q    <= 1'b0;
      rdy_q   <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      tr_q    <= TR;
      rdy_q   <= (state_d == IDLE);
      irq_q   <= ~(sr_rdy_d & sr_ie_d);
    end
  end

  assign RDY = rdy_q;
  assign IRQ = irq_q;

endmodule

// File: doc/pic_input_controller.md
# pic_input_controller

Parallel input controller (PIC): the receive-side counterpart of the POC printer path. A byte-oriented input device (keypad/scanner model) presents data on `PD` with a `TR` strobe against a `RDY` handshake. The PIC latches the byte into BR and sets SR7 "data available". The CPU collects it by query (poll SR7) or interrupt (`IRQ` low), using the same `ADDR`/`RW` bus as the POC.

## Interface
- `DW`, 8, data width of PD, BR, Din and Dout.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `RW`  in  2  CPU bus command: `2'b10` = CPU read, `2'b11` = CPU write, others = idle.
- `ADDR`  in  1  register select: 0 = SR, 1 = BR.
- `Din`  in  DW  CPU write data (SR writes only).
- `Dout`  out  DW  CPU read data, registered.
- `IRQ`  out  1  interrupt request, active-low.
- `TR`  in  1  device strobe; PD valid while TR = 1.
- `PD`  in  DW  device data.
- `RDY`  out  1  1 = PIC can accept a byte.

## Operation
- Status register SR (DW bits):
  - SR7 = data available.
  - SR6 = overrun.
  - SR0 = interrupt enable.
  - All other bits read 0.
- Reset values:
  - SR = 0 and BR = 0.
  - Dout = 0, IRQ = 1, RDY = 1.
  - State = IDLE.
- FSM states:
  - IDLE: RDY = 1.
    - TR = 1 sampled → BR ← PD, SR7 ← 1, RDY ← 0, go to FULL.
  - FULL: RDY = 0, waiting for the CPU to read BR.
    - TR sampled 0→1 (rising edge, detected with a registered copy of TR) → SR6 ← 1; BR is unchanged and the new byte is dropped.
    - CPU read of BR → SR7 ← 0, go to DRAIN.
  - DRAIN: RDY = 0.
    - TR = 0 sampled → RDY ← 1, go to IDLE.
    - While TR stays high, remain in DRAIN. This prevents a single long strobe from being captured twice.
- CPU read, `RW = 10`:
  - ADDR = 0 → Dout ← SR.
  - ADDR = 1 → Dout ← BR. In FULL this also performs the FULL → DRAIN transition.
  - A BR read in IDLE or DRAIN returns the stale BR and changes no state.
- CPU write, `RW = 11`:
  - ADDR = 0 → SR0 ← Din[0]. If Din[6] = 1, SR6 ← 0 (write-1-to-clear).
  - SR7 is not writable.
  - Writes with ADDR = 1 are ignored.
- `RW = 00` or `01`: no bus action; Dout holds its last value.
- IRQ, registered: IRQ ← ~(SR7 & SR0), computed from next-state SR values.
  - Polling mode is SR0 = 0; IRQ stays 1.
- Simultaneous events, all on the same edge:
  - SR read and BR capture: Dout returns the pre-capture SR (SR7 = 0).
  - SR0 write and capture: IRQ reflects both the new SR0 and the new SR7.
  - BR read in FULL with a TR rising edge: the read wins, with no overrun; TR is then handled in DRAIN.
- Reset mid-operation: state, SR, BR, RDY and IRQ all return to their reset values immediately. A byte held in BR is lost.

## Timing
- TR sampled high at edge N:
  - BR valid, SR7 = 1, RDY = 0 after edge N.
  - IRQ = 0 after edge N, if SR0 = 1.
- CPU read with RW sampled at edge M: Dout valid after edge M (1-cycle latency). The CPU samples Dout at edge M+1.
- BR read at edge M:
  - SR7 = 0 and IRQ = 1 after edge M.
  - RDY = 1 after the first edge ≥ M+1 at which TR = 0.
- Minimum capture-to-capture interval: 3 cycles (capture, read, drain).
- Device contract: hold PD stable while TR = 1. TR needs to be high for only one cycle.

## Structure
- Shared package `poc_pkg`, which the POC also imports:
  - RW encodings `RW_READ = 2'b10`, `RW_WRITE = 2'b11`.
  - ADDR encodings `A_SR = 0`, `A_BR = 1`.
  - SR bit indices `SR_RDY = 7`, `SR_OVR = 6`, `SR_IE = 0`.
  - Enum `pic_state_t {IDLE, FULL, DRAIN}`.
- Sub-module `pic_cpu_if`: bus decode and the Dout/SR read-write logic.
- FSM, BR capture, TR edge detect and IRQ generation stay in the top module.

## Test plan
- Reset, then RST = 1 held for 2 cycles → Dout = 0, IRQ = 1, RDY = 1, SR read returns `8'h00`.
- Polling:
  - Stimulus: TR pulse with PD = `8'hA5`, then SR read, then BR read.
  - Response: SR read returns `8'h80`; BR read returns `8'hA5`; the next SR read returns `8'h00`; RDY = 1 one cycle after the read (TR low); IRQ = 1 throughout.
- Interrupt:
  - Stimulus: write SR with Din = `8'h01`, then TR pulse with PD = `8'h3C`.
  - Response: IRQ = 0 the cycle after capture. After the BR read, Dout = `8'h3C` and IRQ = 1 the following cycle.
- Overrun:
  - Stimulus: capture `8'h11`, then a second TR pulse with PD = `8'h22` before any BR read.
  - Response: SR read = `8'hC0`; BR read = `8'h11`; write SR with Din = `8'h40` then read SR → `8'h00`.
- Long strobe: TR held high for 6 cycles with PD = `8'h55`, BR read at cycle 2 → exactly one capture, RDY stays 0 until TR falls, SR6 = 0.
- Reset while in FULL (SR0 = 1, IRQ = 0): assert RST asynchronously between edges → IRQ = 1, RDY = 1, SR = 0 immediately, without waiting for a clock edge.
